// File: rtl/call_pkg.sv
// Shared definitions for the call arbiter slice.
//   - default requester count and operand width
//   - FSM state encoding
//   - modulo-increment helper for the round-robin pointer
package call_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   pending : one bit per requester with an outstanding call
//   rr_ptr  : index to start searching from
//   winner  : first pending index at or after rr_ptr, wrapping modulo N_REQ
//   any     : high when at least one requester is pending
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  int unsigned       idx;
  logic [IDX_W-1:0]  sel;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int unsigned k = 0; k < int'(N_REQ); k++) begin
      idx = (int'(rr_ptr) + k) % int'(N_REQ);
      sel = IDX_W'(idx);
      if (!any && pending[sel]) begin
        any    = 1'b1;
        winner = sel;
      end
    end
  end

endmodule

// File: rtl/call_arbiter.sv
// Shares one start/done callee among N_REQ requesters.
// Each requester pulses req_start with its operands; the call is held
// pending, granted round-robin, issued to the callee, and the result is
// returned on the shared resp_result bus with a one-hot resp_done pulse.
//   clk, reset            : clock, synchronous active-high reset
//   req_start/req_a/req_b : per-requester call pulse and flattened operands
//   resp_done/resp_result : completion pulse and shared result
//   overrun               : sticky, a call was dropped while still pending
//   busy                  : FSM not in IDLE
//   callee_*              : start/done handshake to the shared unit
module call_arbiter
  import call_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_start,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       resp_done,
  output logic [WIDTH-1:0]       resp_result,
  output logic [N_REQ-1:0]       overrun,
  output logic                   busy,
  output logic                   callee_start,
  output logic [WIDTH-1:0]       callee_a,
  output logic [WIDTH-1:0]       callee_b,
  input  logic [WIDTH-1:0]       callee_result,
  input  logic                   callee_done
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t           state, state_nx;
  logic [N_REQ-1:0] pending;
  logic [WIDTH-1:0] op_a [N_REQ];
  logic [WIDTH-1:0] op_b [N_REQ];
  logic [IDX_W-1:0] rr_ptr, grant, winner;
  logic             any;
  logic [WIDTH-1:0] result_q;
  logic [N_REQ-1:0] resp_slot;  // requester being answered this cycle
  logic [N_REQ-1:0] load;       // operand registers capture this cycle

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any     (any)
  );

  // A call arriving in the RESP cycle of its own requester replaces the
  // one being retired, so it loads operands even though pending is still set.
  always_comb begin
    resp_slot = '0;
    load      = '0;
    for (int unsigned i = 0; i < int'(N_REQ); i++) begin
      resp_slot[i] = (state == ST_RESP) && (grant == IDX_W'(i));
      load[i]      = req_start[i] && (!pending[i] || resp_slot[i]);
    end
  end

  always_comb begin
    state_nx     = state;
    busy         = (state != ST_IDLE);
    callee_start = 1'b0;
    resp_done    = '0;
    resp_result  = '0;
    case (state)
      ST_IDLE:  if (any) state_nx = ST_ISSUE;
      ST_ISSUE: begin
        callee_start = 1'b1;
        state_nx     = ST_WAIT;
      end
      ST_WAIT:  if (callee_done) state_nx = ST_RESP;
      ST_RESP: begin
        resp_done[grant] = 1'b1;
        resp_result      = result_q;
        state_nx         = ST_IDLE;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      overrun  <= '0;
      rr_ptr   <= '0;
      grant    <= '0;
      callee_a <= '0;
      callee_b <= '0;
      result_q <= '0;
    end else begin
      if (state == ST_IDLE && any) begin
        grant    <= winner;
        callee_a <= op_a[winner];
        callee_b <= op_b[winner];
      end
      if (state == ST_WAIT && callee_done) result_q <= callee_result;
      if (state == ST_RESP) rr_ptr <= IDX_W'(next_idx(int'(grant), int'(N_REQ)));
      for (int unsigned i = 0; i < int'(N_REQ); i++) begin
        if (req_start[i] && !load[i]) overrun[i] <= 1'b1;
        if (req_start[i])      pending[i] <= 1'b1;
        else if (resp_slot[i]) pending[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < int'(N_REQ); i++) begin
      if (load[i]) begin
        op_a[i] <= req_a[i*WIDTH +: WIDTH];
        op_b[i] <= req_b[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_call_arbiter.sv
// Bench for call_arbiter with a behavioural max-of-two callee behind it.
// Stimulus pushes expected (requester, result) pairs into a queue; a
// monitor on the falling edge pops and compares on every resp_done.
module tb_call_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_start = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   resp_done;
  logic [W-1:0]   resp_result;
  logic [N-1:0]   overrun;
  logic           busy;
  logic           callee_start;
  logic [W-1:0]   callee_a, callee_b;
  logic [W-1:0]   callee_result;
  logic           callee_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          idx;
    logic [W-1:0] val;
  } exp_t;
  exp_t q[$];

  call_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_start     (req_start),
    .req_a         (req_a),
    .req_b         (req_b),
    .resp_done     (resp_done),
    .resp_result   (resp_result),
    .overrun       (overrun),
    .busy          (busy),
    .callee_start  (callee_start),
    .callee_a      (callee_a),
    .callee_b      (callee_b),
    .callee_result (callee_result),
    .callee_done   (callee_done)
  );

  always #5 clk = ~clk;

  // Max-of-two start/done unit, three cycles from start to done.
  int           c_cnt;
  logic [W-1:0] c_max;
  always @(posedge clk) begin
    if (reset) begin
      c_cnt         <= 0;
      c_max         <= '0;
      callee_done   <= 1'b0;
      callee_result <= '0;
    end else begin
      callee_done <= 1'b0;
      if (callee_start) begin
        c_cnt <= 3;
        c_max <= (callee_a > callee_b) ? callee_a : callee_b;
      end else if (c_cnt != 0) begin
        c_cnt <= c_cnt - 1;
        if (c_cnt == 1) begin
          callee_done   <= 1'b1;
          callee_result <= c_max;
        end
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (resp_done != '0) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: resp_done=%b result=%0d, required no response", resp_done, resp_result);
        end else begin
          exp_t e;
          e = q.pop_front();
          checks++;
          if (resp_done !== (4'b0001 << e.idx)) begin
            errors++;
            $display("FAIL resp_order: resp_done=%b, required requester %0d", resp_done, e.idx);
          end
          checks++;
          if (resp_result !== e.val) begin
            errors++;
            $display("FAIL resp_result: got %0d, required %0d (requester %0d)", resp_result, e.val, e.idx);
          end
        end
      end else begin
        checks++;
        if (resp_result !== '0) begin
          errors++;
          $display("FAIL result_idle: got %0d, required 0", resp_result);
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic expect_resp(input int i, input logic [W-1:0] v);
    exp_t e;
    e.idx = i;
    e.val = v;
    q.push_back(e);
  endtask

  // Called just after an edge; returns just after the sampling edge.
  task automatic pulse(input logic [N-1:0] mask);
    req_start = mask;
    @(posedge clk); #1;
    req_start = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && !busy) begin done = 1; break; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: %0d responses outstanding, required 0", name, q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit seen;
    do_reset();
    check("rst_busy", W'(busy), 0);
    check("rst_overrun", W'(overrun), 0);
    check("rst_done", W'(resp_done), 0);
    check("rst_cstart", W'(callee_start), 0);
    check("rst_ca", callee_a, 0);
    check("rst_cb", callee_b, 0);

    // Single call with latency check
    set_ops(0, 1, 2);
    expect_resp(0, 2);
    pulse(4'b0001);
    @(posedge clk); #1;
    check("lat_cstart", W'(callee_start), 1);
    check("lat_ca", callee_a, 1);
    check("lat_cb", callee_b, 2);
    @(posedge clk); #1;
    check("cstart_once", W'(callee_start), 0);
    drain("single");

    // Simultaneous calls from a fresh pointer
    do_reset();
    set_ops(0, 7, 4); set_ops(1, 3, 9); set_ops(2, 5, 5); set_ops(3, 0, 1);
    expect_resp(0, 7); expect_resp(1, 9); expect_resp(2, 5); expect_resp(3, 1);
    pulse(4'b1111);
    drain("simul");

    // Rotation: after serving 2, pointer is 3 so 3 beats 1
    set_ops(2, 4, 6);
    expect_resp(2, 6);
    pulse(4'b0100);
    drain("rot_a");
    set_ops(1, 10, 3); set_ops(3, 2, 11);
    expect_resp(3, 11); expect_resp(1, 10);
    pulse(4'b1010);
    drain("rot_b");

    // Overrun: second pulse while pending is dropped
    set_ops(1, 2, 8);
    expect_resp(1, 8);
    pulse(4'b0010);
    set_ops(1, 9, 9);
    pulse(4'b0010);
    check("overrun_set", W'(overrun), 4'b0010);
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (resp_done[1]) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL overrun_resp_timeout: no resp_done[1], required one");
    end
    // Re-call during RESP is accepted as a fresh call
    set_ops(1, 6, 4);
    expect_resp(1, 6);
    req_start = 4'b0010;
    @(posedge clk); #1;
    req_start = '0;
    check("overrun_kept", W'(overrun), 4'b0010);
    drain("recall");
    check("overrun_after", W'(overrun), 4'b0010);

    // Reset during WAIT abandons the call
    set_ops(0, 3, 2);
    pulse(4'b0001);
    @(posedge clk); @(posedge clk); #1;
    check("wait_busy", W'(busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstwait_busy", W'(busy), 0);
    check("rstwait_overrun", W'(overrun), 0);
    check("rstwait_ca", callee_a, 0);
    repeat (10) @(posedge clk);
    #1;
    check("rstwait_idle", W'(busy), 0);
    set_ops(0, 7, 4);
    expect_resp(0, 7);
    pulse(4'b0001);
    drain("post_reset");

    check("queue_empty", W'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
